// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared widths and the controller state encoding for the instruction-memory
// loader (imem_loader) and its byte packer (byte_packer).
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 8;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Four-byte shift register that assembles a big-endian word: the first byte
// shifted in ends up in the most significant byte after four loads.
//
// Ports
//   clk      in   clock
//   clr      in   synchronous active-high reset
//   clear_i  in   synchronous clear (new load beginning)
//   load_i   in   shift byte_i into the low byte
//   byte_i   in   BYTE_W  incoming stream byte
//   word_o   out  WORD_W  current packed word
// -----------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] word_q;

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (clr || clear_i) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= {word_q[WORD_W-BYTE_W-1:0], byte_i};
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a program over a valid/ready byte stream and writes it, one 32-bit
// word per cycle pulse, into instruction memory while holding the CPU in clear.
// Stream: header N (word count - 1), then 4*(N+1) big-endian payload bytes.
//
// Build option: define LOADER_CHECKSUM_EN to append a checksum byte to the
// stream (XOR of header and payload); a mismatch ends in ERROR instead of DONE.
//
// Ports
//   clk         in   clock, rising edge
//   clr         in   synchronous active-high reset, highest priority
//   start       in   begin a load (honoured in IDLE, DONE, ERROR)
//   byte_valid  in   source has byte_data this cycle
//   byte_data   in   8   stream byte
//   byte_ready  out  loader accepts a byte this cycle
//   mem_wen     out  one-cycle write strobe per word
//   mem_addr    out  8   word address (holds last value between writes)
//   mem_data    out  32  word data (holds last value between writes)
//   cpu_hold    out  CPU held in clear unless load finished in DONE
//   busy        out  load in progress
//   done        out  load finished successfully
//   err         out  checksum mismatch (constant 0 without the checksum build)
// -----------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_data_q, mem_data_d;
    logic [WORD_W-1:0] packed_word;
    logic              pack_load;
    logic              pack_clear;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    byte_packer u_packer (
        .clk     (clk),
        .clr     (clr),
        .clear_i (pack_clear),
        .load_i  (pack_load),
        .byte_i  (byte_data),
        .word_o  (packed_word)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Byte acceptance depends on state only, so byte_valid alone decides a
    // transfer inside each accepting state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        n_d        = n_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        byte_ready = 1'b0;
        mem_wen    = 1'b0;
        pack_load  = 1'b0;
        pack_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_HEADER;
                    addr_d     = '0;
                    cnt_d      = '0;
                    pack_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end

            S_HEADER: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    n_d     = byte_data;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = S_DATA;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = byte_data;
`endif
                end
            end

            S_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    pack_load = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ byte_data;
`endif
                    if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end

            // The packer holds the complete word this cycle; capture it and
            // the address so the memory outputs stay stable afterwards.
            S_WRITE: begin
                mem_wen    = 1'b1;
                mem_addr_d = addr_q;
                mem_data_d = packed_word;
                if (addr_q == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_DATA;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    // During WRITE the live word/address drive memory; otherwise the copies
    // captured on the last write hold the bus steady.
    assign mem_addr = (state_q == S_WRITE) ? addr_q      : mem_addr_q;
    assign mem_data = (state_q == S_WRITE) ? packed_word : mem_data_q;

    assign cpu_hold = (state_q != S_DONE);
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q == S_HEADER) || (state_q == S_DATA) ||
                      (state_q == S_WRITE)  || (state_q == S_CHECK);
`ifdef LOADER_CHECKSUM_EN
    assign err      = (state_q == S_ERROR);
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader: program loads with and without stalls, a full
// 256-word load, mid-load clear, start during DATA, clear/start collision and,
// in the checksum build (LOADER_CHECKSUM_EN), checksum pass and fail.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_wen;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;
    int wen_with_ready = 0;

    logic [7:0]  log_addr[$];
    logic [31:0] log_data[$];

    imem_loader dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Write monitor: samples mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (mem_wen === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
            if (byte_ready !== 1'b0) wen_with_ready++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte until accepted, then drop valid for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (byte_ready !== 1'b1) check("byte_ready_timeout", {63'd0, byte_ready}, 64'd1);
        tick();
        byte_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, (done | err)}, 64'd1);
    endtask

    task automatic load(input logic [7:0] hdr, input byte_q_t body, input int gap, input string tag);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = hdr;
        foreach (body[i]) x ^= body[i];
`endif
        pulse_start();
        send_byte(hdr, gap);
        foreach (body[i]) send_byte(body[i], gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, gap);
`endif
        wait_end(tag);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        wen_with_ready = 0;
    endtask

    initial begin
        byte_q_t prog_a;
        byte_q_t prog_ff;
        int      bad;
        int      zero_hits;

        prog_a = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        for (int k = 0; k < 256; k++) begin
            prog_ff.push_back(8'h00);
            prog_ff.push_back(8'h00);
            prog_ff.push_back(8'h00);
            prog_ff.push_back(8'(k));
        end

        clr        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) tick();
        clr = 1'b0;

        // Reset state
        check("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
        check("rst_mem_wen",    {63'd0, mem_wen},    64'd0);
        check("rst_mem_addr",   {56'd0, mem_addr},   64'd0);
        check("rst_mem_data",   {32'd0, mem_data},   64'd0);
        check("rst_cpu_hold",   {63'd0, cpu_hold},   64'd1);
        check("rst_busy",       {63'd0, busy},       64'd0);
        check("rst_done",       {63'd0, done},       64'd0);
        check("rst_err",        {63'd0, err},        64'd0);

        // Basic two-word load
        clear_log();
        pulse_start();
        check("a_busy_header",  {63'd0, busy},       64'd1);
        check("a_ready_header", {63'd0, byte_ready}, 64'd1);
        send_byte(8'h01, 0);
        foreach (prog_a[i]) send_byte(prog_a[i], 0);
`ifdef LOADER_CHECKSUM_EN
        check("a_cpu_hold_check", {63'd0, cpu_hold}, 64'd1);
        send_byte(8'hAD, 0);
`endif
        wait_end("a_end");
        check("a_writes",    log_addr.size(), 64'd2);
        check("a_addr0",     {56'd0, log_addr[0]}, 64'h00);
        check("a_data0",     {32'd0, log_data[0]}, 64'h2008_0005);
        check("a_addr1",     {56'd0, log_addr[1]}, 64'h01);
        check("a_data1",     {32'd0, log_data[1]}, 64'h8C09_0004);
        check("a_done",      {63'd0, done},     64'd1);
        check("a_cpu_hold",  {63'd0, cpu_hold}, 64'd0);
        check("a_busy",      {63'd0, busy},     64'd0);
        check("a_err",       {63'd0, err},      64'd0);
        check("a_hold_addr", {56'd0, mem_addr}, 64'h01);
        check("a_hold_data", {32'd0, mem_data}, 64'h8C09_0004);
        check("a_wen_idle",  {63'd0, mem_wen},  64'd0);

        // Same stream, three idle cycles between bytes, restarted from DONE
        clear_log();
        load(8'h01, prog_a, 3, "b_end");
        check("b_writes",   log_addr.size(), 64'd2);
        check("b_addr0",    {56'd0, log_addr[0]}, 64'h00);
        check("b_data0",    {32'd0, log_data[0]}, 64'h2008_0005);
        check("b_addr1",    {56'd0, log_addr[1]}, 64'h01);
        check("b_data1",    {32'd0, log_data[1]}, 64'h8C09_0004);
        check("b_ready_in_write", wen_with_ready, 64'd0);
        check("b_done",     {63'd0, done}, 64'd1);

        // Full 256-word load
        clear_log();
        load(8'hFF, prog_ff, 0, "c_end");
        check("c_writes", log_addr.size(), 64'd256);
        bad = 0;
        zero_hits = 0;
        foreach (log_addr[i]) begin
            if (log_addr[i] !== 8'(i) || log_data[i] !== 32'(i)) bad++;
            if (log_addr[i] === 8'h00) zero_hits++;
        end
        check("c_sequence_errors", bad, 64'd0);
        check("c_addr0_writes", zero_hits, 64'd1);
        check("c_last_addr", {56'd0, log_addr[log_addr.size()-1]}, 64'hFF);
        check("c_last_data", {32'd0, log_data[log_data.size()-1]}, 64'h0000_00FF);
        check("c_done", {63'd0, done}, 64'd1);

        // Clear after five payload bytes, then reload
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        for (int i = 0; i < 5; i++) send_byte(prog_a[i], 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("d_cpu_hold",  {63'd0, cpu_hold},   64'd1);
        check("d_busy",      {63'd0, busy},       64'd0);
        check("d_ready",     {63'd0, byte_ready}, 64'd0);
        check("d_mem_addr",  {56'd0, mem_addr},   64'd0);
        check("d_mem_data",  {32'd0, mem_data},   64'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (10) tick();
        byte_valid = 1'b0;
        check("d_writes_before_abort", log_addr.size(), 64'd1);
        check("d_ready_idle", {63'd0, byte_ready}, 64'd0);
        load(8'h01, prog_a, 0, "d_reload_end");
        check("d_writes_total", log_addr.size(), 64'd3);
        check("d_reload_addr0", {56'd0, log_addr[1]}, 64'h00);
        check("d_reload_data0", {32'd0, log_data[1]}, 64'h2008_0005);
        check("d_reload_addr1", {56'd0, log_addr[2]}, 64'h01);
        check("d_reload_data1", {32'd0, log_data[2]}, 64'h8C09_0004);

        // Start pulsed during DATA is ignored
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(prog_a[0], 0);
        send_byte(prog_a[1], 0);
        pulse_start();
        check("e_busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 2; i < 8; i++) send_byte(prog_a[i], 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hAD, 0);
`endif
        wait_end("e_end");
        check("e_writes", log_addr.size(), 64'd2);
        check("e_data0",  {32'd0, log_data[0]}, 64'h2008_0005);
        check("e_data1",  {32'd0, log_data[1]}, 64'h8C09_0004);
        check("e_done",   {63'd0, done}, 64'd1);

        // Clear wins over a simultaneous start
        start = 1'b1;
        clr   = 1'b1;
        tick();
        start = 1'b0;
        clr   = 1'b0;
        check("f_busy",     {63'd0, busy},     64'd0);
        check("f_done",     {63'd0, done},     64'd0);
        check("f_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        check("f_ready",    {63'd0, byte_ready}, 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h04, 0);
        wait_end("g_end_good");
        check("g_good_done", {63'd0, done}, 64'd1);
        check("g_good_err",  {63'd0, err},  64'd0);
        check("g_good_data", {32'd0, log_data[0]}, 64'h0102_0304);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h05, 0);
        wait_end("g_end_bad");
        check("g_bad_err",      {63'd0, err},      64'd1);
        check("g_bad_done",     {63'd0, done},     64'd0);
        check("g_bad_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        check("g_bad_busy",     {63'd0, busy},     64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
